// File: rtl/trig_pkg.sv
// Shared definitions for the trig sequencer and the sine/cosine units:
// degree and Q16 amplitude types, revolution size and sequencer states.
package trig_pkg;

    localparam int TRIG_DEG_FULL = 360;
    localparam int DEG_W         = 9;
    localparam int AMP_Q16_W     = 32;

    typedef logic [DEG_W-1:0]            deg_t;
    typedef logic signed [AMP_Q16_W-1:0] amp_q16_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } seq_state_t;

    // A single conditional subtraction is enough because both operands are below one revolution.
    function automatic deg_t wrap_deg(input logic [DEG_W:0] x, input logic [DEG_W:0] full);
        logic [DEG_W:0] r;
        r = (x >= full) ? x - full : x;
        return r[DEG_W-1:0];
    endfunction

endpackage

// File: rtl/deg_accum.sv
// Modular phase accumulator: loads a start phase and step, advances
// by the step on request, and wraps both modulo one revolution.
module deg_accum
    import trig_pkg::*;
#(
    parameter int DEG_FULL = TRIG_DEG_FULL
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic             advance,
    input  logic [DEG_W-1:0] phase_init,
    input  logic [DEG_W-1:0] step_in,
    output logic [DEG_W-1:0] phase
);

    localparam logic [DEG_W:0] FULL = (DEG_W + 1)'(DEG_FULL);

    logic [DEG_W-1:0] step;
    logic [DEG_W:0]   sum;

    // One extra bit holds phase+step without overflow before the wrap.
    assign sum = {1'b0, phase} + {1'b0, step};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            phase <= '0;
            step  <= '0;
        end else if (load) begin
            phase <= wrap_deg({1'b0, phase_init}, FULL);
            step  <= wrap_deg({1'b0, step_in}, FULL);
        end else if (advance) begin
            phase <= wrap_deg(sum, FULL);
        end
    end

endmodule

// File: rtl/trig_sequencer.sv
// Drives the sine/cosine units one angle at a time, gathers both results
// and hands each (phase, sin, cos) sample downstream over a valid/ready port.
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int DEG_FULL = TRIG_DEG_FULL,
    parameter int AMP_W    = AMP_Q16_W
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable,
    input  logic                    load,
    input  logic [DEG_W-1:0]        phase_init,
    input  logic [DEG_W-1:0]        step_in,
    output logic                    trig_start,
    output logic [DEG_W-1:0]        trig_value,
    input  logic                    sin_done,
    input  logic                    cos_done,
    input  logic signed [AMP_W-1:0] sin_amp,
    input  logic signed [AMP_W-1:0] cos_amp,
    output logic                    samp_valid,
    input  logic                    samp_ready,
    output logic signed [AMP_W-1:0] samp_sin,
    output logic signed [AMP_W-1:0] samp_cos,
    output logic [DEG_W-1:0]        samp_phase,
    output logic [15:0]             samp_count
);

    seq_state_t state, state_next;

    logic                    got_sin, got_cos;
    logic signed [AMP_W-1:0] sin_cap, cos_cap;
    logic                    both_done;
    logic [DEG_W-1:0]        phase;

    // A done arriving this cycle counts as "got", so HOLD follows the last done immediately.
    assign both_done = (state == WAIT) && (got_sin || sin_done) && (got_cos || cos_done);

    deg_accum #(
        .DEG_FULL(DEG_FULL)
    ) u_accum (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load      (load && (state == IDLE)),
        .advance   (both_done),
        .phase_init(phase_init),
        .step_in   (step_in),
        .phase     (phase)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!load && enable) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (both_done) state_next = HOLD;
            HOLD:  if (samp_ready) state_next = enable ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        trig_start = 1'b0;
        samp_valid = 1'b0;
        if (state == ISSUE) trig_start = 1'b1;
        if (state == HOLD)  samp_valid = 1'b1;
    end

    // Sample capture: trig_value is frozen from ISSUE until the sample lands in the output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            trig_value <= '0;
            got_sin    <= 1'b0;
            got_cos    <= 1'b0;
            sin_cap    <= '0;
            cos_cap    <= '0;
            samp_sin   <= '0;
            samp_cos   <= '0;
            samp_phase <= '0;
            samp_count <= '0;
        end else begin
            if (state != ISSUE && state_next == ISSUE) begin
                trig_value <= phase;
            end
            if (both_done) begin
                got_sin    <= 1'b0;
                got_cos    <= 1'b0;
                samp_sin   <= sin_done ? sin_amp : sin_cap;
                samp_cos   <= cos_done ? cos_amp : cos_cap;
                samp_phase <= trig_value;
            end else if (state == WAIT) begin
                if (sin_done) begin
                    got_sin <= 1'b1;
                    sin_cap <= sin_amp;
                end
                if (cos_done) begin
                    got_cos <= 1'b1;
                    cos_cap <= cos_amp;
                end
            end
            if (state == HOLD && samp_ready) begin
                samp_count <= samp_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer with a behavioural sine/cosine unit
// model of programmable latency and hand-computed sample tables.
module tb_trig_sequencer;

    logic               clk_in;
    logic               rst_in;
    logic               enable;
    logic               load;
    logic [8:0]         phase_init;
    logic [8:0]         step_in;
    logic               trig_start;
    logic [8:0]         trig_value;
    logic               sin_done;
    logic               cos_done;
    logic signed [31:0] sin_amp;
    logic signed [31:0] cos_amp;
    logic               samp_valid;
    logic               samp_ready;
    logic signed [31:0] samp_sin;
    logic signed [31:0] samp_cos;
    logic [8:0]         samp_phase;
    logic [15:0]        samp_count;

    int   n_vec;
    int   n_miss;
    int   sin_lat;
    int   cos_lat;
    logic inj_req;

    trig_sequencer #(
        .DEG_FULL(360),
        .AMP_W   (32)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .enable    (enable),
        .load      (load),
        .phase_init(phase_init),
        .step_in   (step_in),
        .trig_start(trig_start),
        .trig_value(trig_value),
        .sin_done  (sin_done),
        .cos_done  (cos_done),
        .sin_amp   (sin_amp),
        .cos_amp   (cos_amp),
        .samp_valid(samp_valid),
        .samp_ready(samp_ready),
        .samp_sin  (samp_sin),
        .samp_cos  (samp_cos),
        .samp_phase(samp_phase),
        .samp_count(samp_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Exact Q16 values at the table angles, an easily hand-computed ramp elsewhere.
    function automatic logic [31:0] amp_of(input logic [8:0] a, input bit is_cos);
        case (a)
            9'd0:    return is_cos ? 32'd65536 : 32'd0;
            9'd30:   return is_cos ? 32'd56756 : 32'd32768;
            9'd60:   return is_cos ? 32'd32768 : 32'd56756;
            9'd90:   return is_cos ? 32'd0     : 32'd65536;
            default: return is_cos ? 32'(-(int'(a) * 256)) : 32'(int'(a) * 256);
        endcase
    endfunction

    // Sine/cosine unit model, stepped 1 time unit after each falling edge.
    int         sin_cnt;
    int         cos_cnt;
    logic [8:0] angle;
    always @(negedge clk_in) begin
        #1;
        sin_done = 1'b0;
        cos_done = 1'b0;
        if (rst_in) begin
            sin_cnt = 0;
            cos_cnt = 0;
        end else begin
            if (sin_cnt > 0) begin
                sin_cnt--;
                if (sin_cnt == 0) begin
                    sin_done = 1'b1;
                    sin_amp  = amp_of(angle, 1'b0);
                end
            end
            if (cos_cnt > 0) begin
                cos_cnt--;
                if (cos_cnt == 0) begin
                    cos_done = 1'b1;
                    cos_amp  = amp_of(angle, 1'b1);
                end
            end
            if (trig_start) begin
                angle   = trig_value;
                sin_cnt = sin_lat;
                cos_cnt = cos_lat;
            end
            if (inj_req) begin
                sin_done = 1'b1;
                cos_done = 1'b1;
                sin_amp  = 32'h7777;
                cos_amp  = 32'h7777;
            end
        end
    end

    typedef struct {
        logic [8:0]       phase_init;
        logic [8:0]       step_in;
        logic [2:0][8:0]  exp_phase;
        logic [2:0][31:0] exp_sin;
        logic [2:0][31:0] exp_cos;
    } vec_t;

    vec_t vecs [4];

    task automatic set_vec(input int idx, input logic [8:0] pi, input logic [8:0] st,
                           input logic [8:0] p0, input logic [8:0] p1, input logic [8:0] p2,
                           input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
        vecs[idx].phase_init   = pi;
        vecs[idx].step_in      = st;
        vecs[idx].exp_phase[0] = p0;
        vecs[idx].exp_phase[1] = p1;
        vecs[idx].exp_phase[2] = p2;
        vecs[idx].exp_sin[0]   = s0;
        vecs[idx].exp_sin[1]   = s1;
        vecs[idx].exp_sin[2]   = s2;
        vecs[idx].exp_cos[0]   = c0;
        vecs[idx].exp_cos[1]   = c1;
        vecs[idx].exp_cos[2]   = c2;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_trig_start"}, 32'(trig_start), 32'd0);
        check_output({tag, "_trig_value"}, 32'(trig_value), 32'd0);
        check_output({tag, "_samp_valid"}, 32'(samp_valid), 32'd0);
        check_output({tag, "_samp_sin"},   samp_sin,        32'd0);
        check_output({tag, "_samp_cos"},   samp_cos,        32'd0);
        check_output({tag, "_samp_phase"}, 32'(samp_phase), 32'd0);
        check_output({tag, "_samp_count"}, 32'(samp_count), 32'd0);
    endtask

    task automatic apply_stimulus_reset();
        rst_in     = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        samp_ready = 1'b0;
        inj_req    = 1'b0;
        sin_lat    = 4;
        cos_lat    = 4;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic apply_stimulus_load(input logic [8:0] pi, input logic [8:0] st);
        phase_init = pi;
        step_in    = st;
        load       = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (!samp_valid && cycles < 100);
        check_output("samp_valid_seen", 32'(samp_valid), 32'd1);
    endtask

    task automatic wait_trig_start();
        int n;
        n = 0;
        while (!trig_start && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check_output("trig_start_seen", 32'(trig_start), 32'd1);
    endtask

    task automatic check_sample(input string tag, input logic [8:0] ph, input logic [31:0] s, input logic [31:0] c);
        check_output({tag, "_phase"}, 32'(samp_phase), 32'(ph));
        check_output({tag, "_sin"},   samp_sin,        s);
        check_output({tag, "_cos"},   samp_cos,        c);
    endtask

    initial begin
        int cyc;
        int bad;
        logic [31:0] held_sin;
        logic [31:0] held_cos;
        logic [8:0]  held_phase;

        n_vec      = 0;
        n_miss     = 0;
        phase_init = '0;
        step_in    = '0;
        sin_done   = 1'b0;
        cos_done   = 1'b0;
        sin_amp    = '0;
        cos_amp    = '0;

        set_vec(0,   9'd0,  9'd30,  9'd0,   9'd30, 9'd60,
                32'd0,     32'd32768, 32'd56756, 32'd65536, 32'd56756, 32'd32768);
        set_vec(1,   9'd350, 9'd20, 9'd350, 9'd10, 9'd30,
                32'd89600, 32'd2560,  32'd32768, 32'(-89600), 32'(-2560), 32'd56756);
        set_vec(2,   9'd0,  9'd400, 9'd0,   9'd40, 9'd80,
                32'd0,     32'd10240, 32'd20480, 32'd65536, 32'(-10240), 32'(-20480));
        set_vec(3,   9'd450, 9'd300, 9'd90, 9'd30, 9'd330,
                32'd65536, 32'd32768, 32'd84480, 32'd0, 32'd56756, 32'(-84480));

        apply_stimulus_reset();
        check_all_zero("reset");

        for (int v = 0; v < 4; v++) begin
            apply_stimulus_reset();
            phase_init = vecs[v].phase_init;
            step_in    = vecs[v].step_in;
            load       = 1'b1;
            enable     = 1'b1;
            samp_ready = 1'b1;
            @(negedge clk_in);
            load = 1'b0;
            check_output("load_beats_enable", 32'(trig_start), 32'd0);
            @(negedge clk_in);
            check_output("issue_start", 32'(trig_start), 32'd1);
            check_output("issue_value", 32'(trig_value), 32'(vecs[v].exp_phase[0]));
            for (int k = 0; k < 3; k++) begin
                wait_valid(cyc);
                check_sample($sformatf("vec%0d_s%0d", v, k),
                             vecs[v].exp_phase[k], vecs[v].exp_sin[k], vecs[v].exp_cos[k]);
                if (k > 0) check_output("period", 32'(cyc), 32'd6);
                if (k == 2) enable = 1'b0;
            end
            @(negedge clk_in);
            check_output("count_after3", 32'(samp_count), 32'd3);
            check_output("valid_drop", 32'(samp_valid), 32'd0);
            bad = 0;
            repeat (4) begin
                @(negedge clk_in);
                if (trig_start || samp_valid) bad++;
            end
            check_output("idle_after_disable", 32'(bad), 32'd0);
        end

        // Backpressure: ten cycles of ready low in HOLD must freeze everything.
        apply_stimulus_reset();
        apply_stimulus_load(9'd0, 9'd30);
        enable = 1'b1;
        wait_valid(cyc);
        held_sin   = samp_sin;
        held_cos   = samp_cos;
        held_phase = samp_phase;
        check_sample("bp_first", 9'd0, 32'd0, 32'd65536);
        bad = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (!samp_valid || trig_start || samp_count != 16'd0 || samp_sin !== held_sin ||
                samp_cos !== held_cos || samp_phase !== held_phase || trig_value != 9'd0) bad++;
        end
        check_output("bp_stable", 32'(bad), 32'd0);
        samp_ready = 1'b1;
        @(negedge clk_in);
        check_output("bp_count", 32'(samp_count), 32'd1);
        check_output("bp_valid_drop", 32'(samp_valid), 32'd0);
        check_output("bp_next_issue", 32'(trig_start), 32'd1);
        check_output("bp_next_value", 32'(trig_value), 32'd30);

        // Skewed done pulses, then simultaneous done pulses.
        apply_stimulus_reset();
        sin_lat = 1;
        cos_lat = 4;
        apply_stimulus_load(9'd0, 9'd30);
        enable     = 1'b1;
        samp_ready = 1'b1;
        wait_valid(cyc);
        check_sample("skew", 9'd0, 32'd0, 32'd65536);
        sin_lat = 4;
        @(negedge clk_in);
        check_output("skew_one_valid", 32'(samp_valid), 32'd0);
        wait_valid(cyc);
        check_sample("same", 9'd30, 32'd32768, 32'd56756);
        enable = 1'b0;
        @(negedge clk_in);
        check_output("same_one_valid", 32'(samp_valid), 32'd0);
        check_output("same_count", 32'(samp_count), 32'd2);

        // Reset while waiting on the trig units, then a stray done after release.
        apply_stimulus_reset();
        apply_stimulus_load(9'd0, 9'd30);
        enable     = 1'b1;
        samp_ready = 1'b1;
        wait_valid(cyc);
        wait_trig_start();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        enable = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        inj_req = 1'b1;
        @(negedge clk_in);
        inj_req = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (trig_start || samp_valid) bad++;
        end
        check_output("stray_done_ignored", 32'(bad), 32'd0);
        check_all_zero("post_rst");
        enable = 1'b1;
        wait_valid(cyc);
        check_sample("post_rst_s0", 9'd0, 32'd0, 32'd65536);
        enable = 1'b0;
        @(negedge clk_in);

        // Load while a sample is in flight must be ignored.
        apply_stimulus_reset();
        apply_stimulus_load(9'd0, 9'd30);
        enable     = 1'b1;
        samp_ready = 1'b1;
        wait_trig_start();
        @(negedge clk_in);
        apply_stimulus_load(9'd90, 9'd90);
        for (int k = 0; k < 3; k++) begin
            wait_valid(cyc);
            check_output($sformatf("midload_phase%0d", k), 32'(samp_phase), 32'(k * 30));
            if (k == 2) enable = 1'b0;
        end
        @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
